// File: rtl/order_tx_serializer.sv
// order_tx_serializer: latches a NUM_WORDS order message and streams it on tvalid/tready/tlast; ORDER_TX_CHECKSUM_EN appends an XOR word.
// First word 1 cycle after i_valid; holds under i_tready=0; i_valid while busy is dropped and counted.
module order_tx_serializer #(
   parameter int REG_WIDTH = 32,
   parameter int NUM_WORDS = 9,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [REG_WIDTH-1:0] i_reg_0,
   input  logic [REG_WIDTH-1:0] i_reg_1,
   input  logic [REG_WIDTH-1:0] i_reg_2,
   input  logic [REG_WIDTH-1:0] i_reg_3,
   input  logic [REG_WIDTH-1:0] i_reg_4,
   input  logic [REG_WIDTH-1:0] i_reg_5,
   input  logic [REG_WIDTH-1:0] i_reg_6,
   input  logic [REG_WIDTH-1:0] i_reg_7,
   input  logic [REG_WIDTH-1:0] i_reg_8,
   input  logic                 i_valid,
   output logic [REG_WIDTH-1:0] o_tdata,
   output logic                 o_tvalid,
   input  logic                 i_tready,
   output logic                 o_tlast,
   output logic                 o_busy,
   output logic [CNT_WIDTH-1:0] o_sent_count,
   output logic [CNT_WIDTH-1:0] o_drop_count
);

`ifdef ORDER_TX_CHECKSUM_EN
   localparam int TOTAL = NUM_WORDS + 1;
`else
   localparam int TOTAL = NUM_WORDS;
`endif
   localparam int IDX_W = $clog2(TOTAL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
   localparam int IN_N = (NUM_WORDS > 9) ? NUM_WORDS : 9;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]           state;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_nxt;
   logic                 tlast_q;
   logic [CNT_WIDTH-1:0] sent_cnt;
   logic [CNT_WIDTH-1:0] drop_cnt;
   logic [REG_WIDTH-1:0] msg_buf   [TOTAL];
   logic [REG_WIDTH-1:0] in_words  [IN_N];
   logic [REG_WIDTH-1:0] cap_words [TOTAL];
   logic                 beat;
   logic                 last_beat;
   logic                 accept;
   logic                 drop;

   // Only nine register ports exist; larger NUM_WORDS builds see zeros beyond word 8.
   always_comb begin
      for (int k = 0; k < IN_N; k++) in_words[k] = '0;
      in_words[0] = i_reg_0;
      in_words[1] = i_reg_1;
      in_words[2] = i_reg_2;
      in_words[3] = i_reg_3;
      in_words[4] = i_reg_4;
      in_words[5] = i_reg_5;
      in_words[6] = i_reg_6;
      in_words[7] = i_reg_7;
      in_words[8] = i_reg_8;
   end

   always_comb begin
      for (int k = 0; k < NUM_WORDS; k++) cap_words[k] = in_words[k];
`ifdef ORDER_TX_CHECKSUM_EN
      cap_words[NUM_WORDS] = '0;
      for (int k = 0; k < NUM_WORDS; k++) cap_words[NUM_WORDS] = cap_words[NUM_WORDS] ^ in_words[k];
`endif
   end

   assign beat      = o_tvalid && i_tready;
   assign last_beat = beat && o_tlast;
   assign accept    = i_valid && ((state == IDLE) || last_beat);
   assign drop      = i_valid && (state == SEND) && !last_beat;
   assign idx_nxt   = idx + IDX_W'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         tlast_q  <= 1'b0;
         sent_cnt <= '0;
         drop_cnt <= '0;
         for (int k = 0; k < TOTAL; k++) msg_buf[k] <= '0;
      end else begin
         // A new message may overwrite the buffer on the very cycle the old one finishes.
         if (accept) begin
            for (int k = 0; k < TOTAL; k++) msg_buf[k] <= cap_words[k];
            idx     <= '0;
            state   <= SEND;
            tlast_q <= 1'b0;
         end else if (last_beat) begin
            idx     <= '0;
            state   <= IDLE;
            tlast_q <= 1'b0;
         end else if (beat) begin
            idx     <= idx_nxt;
            tlast_q <= (idx_nxt == LAST_IDX);
         end

         if (last_beat && (sent_cnt != '1)) sent_cnt <= sent_cnt + CNT_WIDTH'(1);
         if (drop && (drop_cnt != '1))      drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
   end

   assign o_tvalid     = (state == SEND);
   assign o_busy       = (state == SEND);
   assign o_tlast      = tlast_q;
   assign o_tdata      = msg_buf[idx];
   assign o_sent_count = sent_cnt;
   assign o_drop_count = drop_cnt;

endmodule

// File: tb/tb_order_tx_serializer.sv
// Bench for order_tx_serializer: directed scenarios plus random traffic against a queue-based message model.
`timescale 1ns/1ps
module tb_order_tx_serializer;
   localparam int W  = 32;
   localparam int N  = 9;
   localparam int CW = 16;
`ifdef ORDER_TX_CHECKSUM_EN
   localparam int TOTAL = N + 1;
`else
   localparam int TOTAL = N;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  regs [N];
   logic          valid = 1'b0;
   logic          tready = 1'b0;
   logic [W-1:0]  tdata;
   logic          tvalid;
   logic          tlast;
   logic          busy;
   logic [CW-1:0] sent_count;
   logic [CW-1:0] drop_count;

   int checks = 0;
   int errors = 0;

   // Reference model: words still owed on the stream for the current message.
   logic [W-1:0] exp_q [$];
   int exp_sent = 0;
   int exp_drop = 0;

   always #5 clk = ~clk;

   order_tx_serializer #(.REG_WIDTH(W), .NUM_WORDS(N), .CNT_WIDTH(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_reg_0(regs[0]), .i_reg_1(regs[1]), .i_reg_2(regs[2]),
      .i_reg_3(regs[3]), .i_reg_4(regs[4]), .i_reg_5(regs[5]),
      .i_reg_6(regs[6]), .i_reg_7(regs[7]), .i_reg_8(regs[8]),
      .i_valid(valid), .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready),
      .o_tlast(tlast), .o_busy(busy),
      .o_sent_count(sent_count), .o_drop_count(drop_count)
   );

   function automatic void model_reset();
      exp_q.delete();
      exp_sent = 0;
      exp_drop = 0;
   endfunction

   function automatic void model_step(input logic v, input logic r);
      logic         did_beat;
      logic         was_last;
      logic [W-1:0] cs;
      did_beat = (exp_q.size() != 0) && r;
      was_last = did_beat && (exp_q.size() == 1);
      if (did_beat) void'(exp_q.pop_front());
      if (was_last) exp_sent++;
      if (v) begin
         if (exp_q.size() == 0) begin
            cs = '0;
            for (int k = 0; k < N; k++) begin
               exp_q.push_back(regs[k]);
               cs = cs ^ regs[k];
            end
`ifdef ORDER_TX_CHECKSUM_EN
            exp_q.push_back(cs);
`endif
         end else begin
            exp_drop++;
         end
      end
   endfunction

   task automatic set_regs(input logic [W-1:0] base);
      for (int k = 0; k < N; k++) regs[k] = base + W'(k);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b0; tready = 1'b0;
      set_regs(32'h0);
      repeat (2) @(negedge clk);
      model_reset();
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", tvalid); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", tlast); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h exp 0", tdata); end
      checks++; if (sent_count !== '0) begin errors++; $display("FAIL reset_sent got %0d exp 0", sent_count); end
      checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_send();
      set_regs(32'h1000);
      for (int c = 0; c < 14; c++) begin
         valid = (c == 0); tready = 1'b1;
         checks++; if (tvalid !== (exp_q.size() != 0)) begin errors++; $display("FAIL basic_tvalid cyc %0d got %b exp %b", c, tvalid, exp_q.size() != 0); end
         checks++; if (busy !== (exp_q.size() != 0)) begin errors++; $display("FAIL basic_busy cyc %0d got %b exp %b", c, busy, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (tdata !== exp_q[0]) begin errors++; $display("FAIL basic_tdata cyc %0d got %h exp %h", c, tdata, exp_q[0]); end
            checks++; if (tlast !== (exp_q.size() == 1)) begin errors++; $display("FAIL basic_tlast cyc %0d got %b exp %b", c, tlast, exp_q.size() == 1); end
         end
         model_step(valid, tready);
         @(negedge clk);
      end
      valid = 1'b0;
      checks++; if (sent_count !== CW'(exp_sent)) begin errors++; $display("FAIL basic_sent got %0d exp %0d", sent_count, exp_sent); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] prev_d = '0;
      logic         prev_l = 1'b0;
      logic         prev_stall = 1'b0;
      set_regs(32'h1000);
      for (int c = 0; c < 34; c++) begin
         valid = (c == 0); tready = (c % 3 == 0);
         checks++; if (tvalid !== (exp_q.size() != 0)) begin errors++; $display("FAIL bp_tvalid cyc %0d got %b exp %b", c, tvalid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (tdata !== exp_q[0]) begin errors++; $display("FAIL bp_tdata cyc %0d got %h exp %h", c, tdata, exp_q[0]); end
            checks++; if (tlast !== (exp_q.size() == 1)) begin errors++; $display("FAIL bp_tlast cyc %0d got %b exp %b", c, tlast, exp_q.size() == 1); end
         end
         if (prev_stall) begin
            checks++; if (tdata !== prev_d || tlast !== prev_l) begin errors++; $display("FAIL bp_hold cyc %0d got %h/%b exp %h/%b", c, tdata, tlast, prev_d, prev_l); end
         end
         prev_stall = (exp_q.size() != 0) && !tready;
         prev_d = tdata; prev_l = tlast;
         model_step(valid, tready);
         @(negedge clk);
      end
      valid = 1'b0;
      checks++; if (sent_count !== CW'(exp_sent)) begin errors++; $display("FAIL bp_sent got %0d exp %0d", sent_count, exp_sent); end
   endtask

   task automatic test_drop();
      bit dropped = 0;
      set_regs(32'h1000);
      for (int c = 0; c < 14; c++) begin
         valid = (c == 0); tready = 1'b1;
         if (!dropped && exp_q.size() == TOTAL - 2) begin
            valid = 1'b1; dropped = 1;
            set_regs(32'hBEEF0000);
         end
         checks++; if (tvalid !== (exp_q.size() != 0)) begin errors++; $display("FAIL drop_tvalid cyc %0d got %b exp %b", c, tvalid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (tdata !== exp_q[0]) begin errors++; $display("FAIL drop_tdata cyc %0d got %h exp %h", c, tdata, exp_q[0]); end
            checks++; if (tlast !== (exp_q.size() == 1)) begin errors++; $display("FAIL drop_tlast cyc %0d got %b exp %b", c, tlast, exp_q.size() == 1); end
         end
         model_step(valid, tready);
         @(negedge clk);
      end
      valid = 1'b0;
      checks++; if (drop_count !== CW'(exp_drop)) begin errors++; $display("FAIL drop_count got %0d exp %0d", drop_count, exp_drop); end
      checks++; if (sent_count !== CW'(exp_sent)) begin errors++; $display("FAIL drop_sent got %0d exp %0d", sent_count, exp_sent); end
   endtask

   task automatic test_back_to_back();
      bit second = 0;
      set_regs(32'h1000);
      for (int c = 0; c < 24; c++) begin
         valid = (c == 0); tready = 1'b1;
         if (!second && exp_q.size() == 1) begin
            valid = 1'b1; second = 1;
            set_regs(32'h2000);
         end
         checks++; if (tvalid !== (exp_q.size() != 0)) begin errors++; $display("FAIL b2b_tvalid cyc %0d got %b exp %b", c, tvalid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (tdata !== exp_q[0]) begin errors++; $display("FAIL b2b_tdata cyc %0d got %h exp %h", c, tdata, exp_q[0]); end
            checks++; if (tlast !== (exp_q.size() == 1)) begin errors++; $display("FAIL b2b_tlast cyc %0d got %b exp %b", c, tlast, exp_q.size() == 1); end
         end
         model_step(valid, tready);
         @(negedge clk);
      end
      valid = 1'b0;
      checks++; if (drop_count !== CW'(exp_drop)) begin errors++; $display("FAIL b2b_drop got %0d exp %0d", drop_count, exp_drop); end
      checks++; if (sent_count !== CW'(exp_sent)) begin errors++; $display("FAIL b2b_sent got %0d exp %0d", sent_count, exp_sent); end
   endtask

   task automatic test_mid_reset();
      bit fired = 0;
      set_regs(32'h1000);
      for (int c = 0; c < 30; c++) begin
         rst_n = 1'b1; valid = (c == 0 || c == 12); tready = 1'b1;
         if (c == 12) for (int k = 0; k < N; k++) regs[k] = $urandom;
         checks++; if (tvalid !== (exp_q.size() != 0)) begin errors++; $display("FAIL mrst_tvalid cyc %0d got %b exp %b", c, tvalid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (tdata !== exp_q[0]) begin errors++; $display("FAIL mrst_tdata cyc %0d got %h exp %h", c, tdata, exp_q[0]); end
            checks++; if (tlast !== (exp_q.size() == 1)) begin errors++; $display("FAIL mrst_tlast cyc %0d got %b exp %b", c, tlast, exp_q.size() == 1); end
         end
         if (!fired && exp_q.size() == TOTAL - 4) begin
            rst_n = 1'b0; valid = 1'b0; fired = 1;
            model_reset();
         end else begin
            model_step(valid, tready);
         end
         @(negedge clk);
         if (rst_n == 1'b0) begin
            checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_idle got %b/%b exp 0/0", tvalid, busy); end
            checks++; if (sent_count !== '0 || drop_count !== '0) begin errors++; $display("FAIL mrst_counts got %0d/%0d exp 0/0", sent_count, drop_count); end
         end
      end
      rst_n = 1'b1; valid = 1'b0;
      checks++; if (sent_count !== CW'(exp_sent)) begin errors++; $display("FAIL mrst_sent got %0d exp %0d", sent_count, exp_sent); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         valid  = ($urandom_range(0, 3) == 0);
         tready = ($urandom_range(0, 2) != 0);
         for (int k = 0; k < N; k++) regs[k] = $urandom;
         checks++; if (tvalid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_tvalid cyc %0d got %b exp %b", c, tvalid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (tdata !== exp_q[0]) begin errors++; $display("FAIL rnd_tdata cyc %0d got %h exp %h", c, tdata, exp_q[0]); end
            checks++; if (tlast !== (exp_q.size() == 1)) begin errors++; $display("FAIL rnd_tlast cyc %0d got %b exp %b", c, tlast, exp_q.size() == 1); end
         end
         checks++; if (sent_count !== CW'(exp_sent) || drop_count !== CW'(exp_drop)) begin
            errors++; $display("FAIL rnd_counts cyc %0d got %0d/%0d exp %0d/%0d", c, sent_count, drop_count, exp_sent, exp_drop);
         end
         model_step(valid, tready);
         @(negedge clk);
      end
      valid = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < N; k++) regs[k] = '0;
      @(negedge clk);
      test_reset();
      test_basic_send();
      test_backpressure();
      test_drop();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
